// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types, visible-area geometry and pipeline-depth helper for the scaled pixel fetch.
package vga_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12;

  localparam int VIS_W = 800;
  localparam int VIS_H = 600;

  typedef enum logic [2:0] {
    WAIT_FRAME,
    WAIT_ROW,
    IN_ROW,
    ROW_END,
    DONE
  } fetch_state;

  // Decode-ahead distance: one cycle to register the address, ROM latency, one output register.
  function automatic int pipe_depth(input int rom_lat);
    return rom_lat + 2;
  endfunction

endpackage

// File: rtl/vga_pipe_delay.sv
// rtl/vga_pipe_delay.sv - fixed-depth shift register that carries decode tags alongside the ROM read.
module vga_pipe_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= data_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign data_out = stage[DEPTH-1];

endmodule

// File: rtl/vga_scaled_pixel_fetch.sv
// rtl/vga_scaled_pixel_fetch.sv - decodes VGA counts ahead into ROM addresses and returns
// count-aligned, SCALE-replicated 12-bit RGB for an image placed at a latched offset.
module vga_scaled_pixel_fetch #(
  parameter int IMG_W   = 300,
  parameter int IMG_H   = 250,
  parameter int SCALE   = 2,
  parameter int ROM_LAT = 1,
  parameter int ADDR_W  = 19,
  parameter int CNT_W   = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [CNT_W-1:0]  pixel_count,
  input  logic [CNT_W-1:0]  line_count,
  input  logic [CNT_W-1:0]  horizontal_back_porch,
  input  logic [CNT_W-1:0]  vertical_back_porch,
  input  logic [CNT_W-1:0]  x_offset,
  input  logic [CNT_W-1:0]  y_offset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [3:0]        red_out,
  output logic [3:0]        green_out,
  output logic [3:0]        blue_out,
  output logic              pixel_valid,
  output logic              frame_done
);

  import vga_pkg::*;

  localparam int D     = pipe_depth(ROM_LAT);
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int REP_W = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(SCALE - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
  localparam logic [CNT_W-1:0]  WIN_H     = CNT_W'(IMG_H * SCALE);
  localparam logic [CNT_W-1:0]  LOOKAHEAD = CNT_W'(D);

  fetch_state        state;
  logic [CNT_W-1:0]  xo;
  logic [CNT_W-1:0]  yo;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] addr_cur;
  logic [COL_W-1:0]  col_idx;
  logic [REP_W-1:0]  col_rep;
  logic [REP_W-1:0]  line_rep;
  logic [ROW_W-1:0]  row_idx;
  logic              dec_valid;
  logic              dec_done;
  logic [1:0]        piped;
  rgb12              pix;

  logic              frame_start;
  logic [CNT_W-1:0]  look_col;
  logic [CNT_W-1:0]  col_start;
  logic [CNT_W-1:0]  line_top;
  logic              on_win_line;
  logic              row_hit;
  logic              emit;
  logic              col_wrap;
  logic              row_last_col;

  assign frame_start  = (pixel_count == '0) && (line_count == '0);
  assign look_col     = pixel_count + LOOKAHEAD;
  assign col_start    = horizontal_back_porch + xo;
  assign line_top     = vertical_back_porch + yo;
  assign on_win_line  = (line_count >= line_top) && (line_count < line_top + WIN_H);
  assign row_hit      = (state == WAIT_ROW) && on_win_line && (look_col == col_start);
  assign emit         = row_hit || (state == IN_ROW);
  assign col_wrap     = (col_rep == REP_LAST);
  assign row_last_col = col_wrap && (col_idx == COL_LAST);

  // Decode stage: everything here describes the column pixel_count+D, not the current one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= WAIT_FRAME;
      xo        <= '0;
      yo        <= '0;
      row_base  <= '0;
      addr_cur  <= '0;
      col_idx   <= '0;
      col_rep   <= '0;
      line_rep  <= '0;
      row_idx   <= '0;
      rom_addr  <= '0;
      dec_valid <= 1'b0;
      dec_done  <= 1'b0;
    end else begin
      dec_valid <= 1'b0;
      dec_done  <= 1'b0;
      if (frame_start) begin
        // Also the recovery path when a frame start arrives mid-fetch: restart from address 0.
        xo       <= x_offset;
        yo       <= y_offset;
        row_base <= '0;
        addr_cur <= '0;
        col_idx  <= '0;
        col_rep  <= '0;
        line_rep <= '0;
        row_idx  <= '0;
        state    <= enable ? WAIT_ROW : WAIT_FRAME;
      end else if (emit) begin
        rom_addr  <= addr_cur;
        dec_valid <= 1'b1;
        if (!col_wrap) begin
          col_rep <= col_rep + 1'b1;
        end else begin
          col_rep <= '0;
          if (col_idx == COL_LAST) begin
            col_idx <= '0;
          end else begin
            col_idx  <= col_idx + 1'b1;
            addr_cur <= addr_cur + 1'b1;
          end
        end
        state <= row_last_col ? ROW_END : IN_ROW;
      end else begin
        case (state)
          ROW_END: begin
            if ((line_rep == REP_LAST) && (row_idx == ROW_LAST)) begin
              dec_done <= 1'b1;
              state    <= DONE;
            end else begin
              state <= WAIT_ROW;
              if (line_rep == REP_LAST) begin
                line_rep <= '0;
                row_idx  <= row_idx + 1'b1;
                row_base <= row_base + ROW_STEP;
                addr_cur <= row_base + ROW_STEP;
              end else begin
                line_rep <= line_rep + 1'b1;
                addr_cur <= row_base;
              end
            end
          end
          DONE: begin
            if (frame_done) state <= WAIT_FRAME;
          end
          default: ;
        endcase
      end
    end
  end

  // ROM_LAT stages line the tags up with rom_data; the output register below is the last stage.
  vga_pipe_delay #(
    .DEPTH (ROM_LAT),
    .WIDTH (2)
  ) u_pipe (
    .clock    (clock),
    .reset_n  (reset_n),
    .data_in  ({dec_valid, dec_done}),
    .data_out (piped)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      pix         <= '0;
    end else begin
      pixel_valid <= piped[1];
      frame_done  <= piped[0];
      pix         <= piped[1] ? rgb12'(rom_data) : '0;
    end
  end

  assign red_out   = pix.r;
  assign green_out = pix.g;
  assign blue_out  = pix.b;

endmodule

// File: tb/tb_vga_scaled_pixel_fetch.sv
// tb/tb_vga_scaled_pixel_fetch.sv - scoreboard bench driving SCALE=2 and SCALE=1 instances from shared counts.
module tb_vga_scaled_pixel_fetch;

  localparam int W       = 12;
  localparam int H       = 6;
  localparam int HBP     = 10;
  localparam int VBP     = 3;
  localparam int H_TOTAL = 64;
  localparam int V_TOTAL = 26;
  localparam int AW      = 19;
  localparam int CW      = 32;

  typedef struct packed {
    logic [11:0] rgb;
    logic        valid;
    logic        done;
  } exp_t;

  logic          clock;
  logic          reset_n;
  logic          enable;
  logic [CW-1:0] pixel_count;
  logic [CW-1:0] line_count;
  logic [CW-1:0] hbp;
  logic [CW-1:0] vbp;
  logic [CW-1:0] x_offset;
  logic [CW-1:0] y_offset;

  logic [AW-1:0] rom_addr2, rom_addr1;
  logic [11:0]   rom_data2, rom_data1;
  logic [3:0]    r2, g2, b2, r1, g1, b1;
  logic          pv2, pv1, fd2, fd1;

  logic [11:0] rom [W*H];
  exp_t        q2[$];
  exp_t        q1[$];
  int          n_cmp;
  int          n_bad;
  bit          f_active;
  int          f_xo;
  int          f_yo;

  vga_scaled_pixel_fetch #(
    .IMG_W(W), .IMG_H(H), .SCALE(2), .ROM_LAT(1), .ADDR_W(AW), .CNT_W(CW)
  ) dut2 (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .pixel_count(pixel_count), .line_count(line_count),
    .horizontal_back_porch(hbp), .vertical_back_porch(vbp),
    .x_offset(x_offset), .y_offset(y_offset),
    .rom_addr(rom_addr2), .rom_data(rom_data2),
    .red_out(r2), .green_out(g2), .blue_out(b2),
    .pixel_valid(pv2), .frame_done(fd2)
  );

  vga_scaled_pixel_fetch #(
    .IMG_W(W), .IMG_H(H), .SCALE(1), .ROM_LAT(1), .ADDR_W(AW), .CNT_W(CW)
  ) dut1 (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .pixel_count(pixel_count), .line_count(line_count),
    .horizontal_back_porch(hbp), .vertical_back_porch(vbp),
    .x_offset(x_offset), .y_offset(y_offset),
    .rom_addr(rom_addr1), .rom_data(rom_data1),
    .red_out(r1), .green_out(g1), .blue_out(b1),
    .pixel_valid(pv1), .frame_done(fd1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [11:0] rom_rd(input logic [AW-1:0] a);
    return (a < AW'(W * H)) ? rom[a[6:0]] : 12'h000;
  endfunction

  always @(posedge clock) begin
    rom_data2 <= rom_rd(rom_addr2);
    rom_data1 <= rom_rd(rom_addr1);
  end

  // Image pixel (p,l) for replication factor s, from the window geometry latched at frame start.
  function automatic exp_t model(input int s, input int p, input int l);
    exp_t e;
    int   c0, r0;
    e  = '0;
    c0 = HBP + f_xo;
    r0 = VBP + f_yo;
    if (f_active) begin
      if (p >= c0 && p < c0 + W * s && l >= r0 && l < r0 + H * s) begin
        e.valid = 1'b1;
        e.rgb   = rom[((l - r0) / s) * W + (p - c0) / s];
      end
      e.done = (l == r0 + H * s - 1) && (p == c0 + W * s);
    end
    return e;
  endfunction

  task automatic drive(input int p, input int l, input bit rst_n, input bit en, input int xo, input int yo);
    @(posedge clock);
    #1;
    pixel_count = CW'(p);
    line_count  = CW'(l);
    reset_n     = rst_n;
    enable      = en;
    x_offset    = CW'(xo);
    y_offset    = CW'(yo);
    if (!rst_n) begin
      f_active = 1'b0;
    end else if (p == 0 && l == 0) begin
      f_active = en;
      f_xo     = xo;
      f_yo     = yo;
    end
    q2.push_back(model(2, p, l));
    q1.push_back(model(1, p, l));
  endtask

  task automatic check_px(input string name, input logic [11:0] rgb, input logic v, input logic d, input exp_t e);
    n_cmp++;
    if ({rgb, v, d} !== {e.rgb, e.valid, e.done}) begin
      n_bad++;
      $display("FAIL %s at (%0d,%0d): got rgb=%h valid=%b done=%b, expected rgb=%h valid=%b done=%b",
               name, pixel_count, line_count, rgb, v, d, e.rgb, e.valid, e.done);
    end
  endtask

  task automatic check_addr(input string name, input logic [AW-1:0] got, input bit ok, input int req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s at (%0d,%0d): rom_addr=%0d, required %0d", name, pixel_count, line_count, got, req);
    end
  endtask

  always @(negedge clock) begin
    if (q2.size() > 0) check_px("pixel_s2", {r2, g2, b2}, pv2, fd2, q2.pop_front());
    if (q1.size() > 0) check_px("pixel_s1", {r1, g1, b1}, pv1, fd1, q1.pop_front());
    check_addr("addr_bound_s2", rom_addr2, rom_addr2 <= AW'(W * H - 1), W * H - 1);
    check_addr("addr_bound_s1", rom_addr1, rom_addr1 <= AW'(W * H - 1), W * H - 1);
    if (f_active && pixel_count == CW'(HBP + f_xo - 2) && line_count == CW'(VBP + f_yo)) begin
      check_addr("first_fetch_s2", rom_addr2, rom_addr2 == '0, 0);
      check_addr("first_fetch_s1", rom_addr1, rom_addr1 == '0, 0);
    end
  end

  initial begin
    int xo, yo, cur_xo, cur_yo;
    bit en, cur_en, cur_rst, stop;
    n_cmp = 0;
    n_bad = 0;
    f_active = 1'b0;
    f_xo = 0;
    f_yo = 0;
    hbp = CW'(HBP);
    vbp = CW'(VBP);
    reset_n = 1'b0;
    enable = 1'b0;
    pixel_count = CW'(40);
    line_count = CW'(V_TOTAL - 1);
    x_offset = '0;
    y_offset = '0;
    for (int i = 0; i < W * H; i++) rom[i] = 12'($urandom);

    for (int p = 40; p < H_TOTAL; p++) drive(p, V_TOTAL - 1, p >= 44, 1'b0, 0, 0);

    cur_rst = 1'b1;
    for (int fr = 0; fr < 10; fr++) begin
      xo = $urandom_range(0, 20);
      yo = $urandom_range(0, 8);
      en = (fr == 1) ? 1'b0 : (fr >= 6 ? ($urandom_range(0, 3) != 0) : 1'b1);
      cur_xo = xo;
      cur_yo = yo;
      cur_en = en;
      stop = 1'b0;
      for (int l = 0; l < V_TOTAL; l++) begin
        for (int p = 0; p < H_TOTAL; p++) begin
          if (l == 2 && p == 5 && (fr == 1 || fr >= 6)) cur_en = !cur_en;
          if (l == 4 && p == 7 && (fr == 2 || fr >= 6)) begin
            cur_xo = $urandom_range(0, 20);
            cur_yo = $urandom_range(0, 8);
          end
          if (fr == 3 && l == VBP + yo + 3 && p == HBP + xo + 5) cur_rst = 1'b0;
          if (fr == 3 && l == VBP + yo + 3 && p == HBP + xo + 7) cur_rst = 1'b1;
          drive(p, l, cur_rst, cur_en, cur_xo, cur_yo);
          // Frame 5 is cut short outside the window so the next frame start arrives mid-fetch.
          if (fr == 5 && l == VBP + yo + 4 && p == H_TOTAL - 1) stop = 1'b1;
          if (stop) break;
        end
        if (stop) break;
      end
    end

    for (int p = 1; p < 6; p++) drive(p, 0, 1'b1, 1'b0, 0, 0);
    @(negedge clock);
    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
